prold_loader: RTL and testbench

PROLD_LOADER -- requirements
Module: prold_loader

---
 rtl/prold_loader_if.sv | 30 +++
 rtl/prold_loader.sv | 156 +++++++++++++++
 tb/tb_prold_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prold_loader_if.sv
// rtl/prold_loader_if.sv - UART-side and fetch-side signal bundle for the program loader
//
// Signals:
//   rx_valid, rx_data  : received UART byte, never back-pressured
//   tx_valid, tx_ready : ack byte handshake (transfer when both high)
//   tx_data            : ack byte
//   prold_info         : packed {mode, order, pc, data} for the fetch unit
// Modports:
//   master : the environment (drives rx and tx_ready, observes tx and prold_info)
//   slave  : the loader itself
interface prold_loader_if #(
    parameter int LEN_PROLD_INFO = 66
) ();
    logic                      rx_valid;
    logic [7:0]                rx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [7:0]                tx_data;
    logic [LEN_PROLD_INFO-1:0] prold_info;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, prold_info
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, prold_info
    );
endinterface

// File: rtl/prold_loader.sv
// rtl/prold_loader.sv - UART program loader streaming instruction words to the fetch unit
//
// Ports:
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-high reset
//   start : one-cycle request to begin a load (honoured only in IDLE)
//   bus   : prold_loader_if.slave (rx byte stream, tx ack handshake, prold_info)
// Load format: 4-byte big-endian word count N, then N 4-byte big-endian words.
// Each completed word produces a one-cycle order pulse with its pc/data.
// Optional macro PROLD_CHECKSUM_EN: one trailing byte is compared with the XOR
// of all size and data bytes; ack is 8'hAA on match, 8'h55 otherwise. Without
// it, the ack is always 8'hAA and no checksum byte is expected.
module prold_loader #(
    parameter int LEN_WORD       = 32,
    parameter int LEN_PROLD_INFO = 2*LEN_WORD+2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    prold_loader_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SIZE, DATA, CHECK, ACK} state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         shift_q, shift_d;       // first three bytes of the word in flight
    logic [31:0]         rem_q, rem_d;           // words still to receive
    logic [LEN_WORD-1:0] next_pc_q, next_pc_d;   // address for the next completed word
    logic [LEN_WORD-1:0] pc_q, pc_d;
    logic [LEN_WORD-1:0] data_q, data_d;
    logic                order_q, order_d;
    logic [7:0]          tx_data_q, tx_data_d;
`ifdef PROLD_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic        rx_take;
    logic        word_done;
    logic [31:0] word;
    logic        mode;

    assign rx_take   = bus.rx_valid && (state_q == SIZE || state_q == DATA);
    assign word_done = rx_take && (byte_cnt_q == 2'd3);
    assign word      = {shift_q, bus.rx_data};
    assign mode      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        rem_d      = rem_q;
        next_pc_d  = next_pc_q;
        pc_d       = pc_q;
        data_d     = data_q;
        order_d    = 1'b0;
        tx_data_d  = tx_data_q;
`ifdef PROLD_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // Byte counter wraps naturally after four bytes, so it is already
        // zero when SIZE hands over to DATA.
        if (rx_take) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], bus.rx_data};
`ifdef PROLD_CHECKSUM_EN
            csum_d     = csum_q ^ bus.rx_data;
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SIZE;
                    byte_cnt_d = 2'd0;
                    rem_d      = 32'd0;
                    next_pc_d  = '0;
                    pc_d       = '0;
`ifdef PROLD_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            SIZE: begin
                if (word_done) begin
                    rem_d   = word;
                    state_d = (word == 32'd0) ? CHECK : DATA;
                end
            end
            DATA: begin
                if (word_done) begin
                    order_d   = 1'b1;
                    pc_d      = next_pc_q;
                    next_pc_d = next_pc_q + LEN_WORD'(4);
                    data_d    = LEN_WORD'(word);
                    rem_d     = rem_q - 32'd1;
                    // The last word's order pulse is issued while already in CHECK.
                    if (rem_q == 32'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
`ifdef PROLD_CHECKSUM_EN
                if (bus.rx_valid) begin
                    tx_data_d = (bus.rx_data == csum_q) ? 8'hAA : 8'h55;
                    state_d   = ACK;
                end
`else
                tx_data_d = 8'hAA;
                state_d   = ACK;
`endif
            end
            ACK: begin
                if (bus.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            rem_q      <= 32'd0;
            next_pc_q  <= '0;
            pc_q       <= '0;
            data_q     <= '0;
            order_q    <= 1'b0;
            tx_data_q  <= 8'd0;
`ifdef PROLD_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            rem_q      <= rem_d;
            next_pc_q  <= next_pc_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            order_q    <= order_d;
            tx_data_q  <= tx_data_d;
`ifdef PROLD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.tx_valid   = (state_q == ACK);
    assign bus.tx_data    = tx_data_q;
    assign bus.prold_info = LEN_PROLD_INFO'({mode, order_q, pc_q, data_q});
endmodule

// File: tb/tb_prold_loader.sv
// tb/tb_prold_loader.sv - scoreboard bench for prold_loader with randomized loads
module tb_prold_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    prold_loader_if #(.LEN_PROLD_INFO(66)) bus ();

    prold_loader #(.LEN_WORD(32), .LEN_PROLD_INFO(66)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] cyc;
    } ord_t;

    ord_t        exp_ord[$];
    logic [7:0]  exp_ack[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  cur_csum;
    bit          b2b;
    logic [31:0] wbuf [0:15];
    ord_t        mon_e;
    logic [7:0]  mon_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every order pulse and ack handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.prold_info[64]) begin
                chk("order_mode", 64'(bus.prold_info[65]), 64'd1);
                if (exp_ord.size() == 0) begin
                    chk("unexpected_order", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_ord.pop_front();
                    chk("order_pc",   64'(bus.prold_info[63:32]), 64'(mon_e.pc));
                    chk("order_data", 64'(bus.prold_info[31:0]),  64'(mon_e.data));
                    chk("order_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_ack.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    mon_a = exp_ack.pop_front();
                    chk("ack_byte", 64'(bus.tx_data), 64'(mon_a));
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input logic [31:0] pc, input logic [31:0] w);
        ord_t e;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cur_csum     = cur_csum ^ b;
        if (last) begin
            e.pc   = pc;
            e.data = w;
            e.cyc  = 32'(cyc + 1);
            exp_ord.push_back(e);
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        if (!b2b) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input logic [31:0] pc);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], last && (i == 0), pc, w);
        end
    endtask

    task automatic wait_ack(input int hold, input bit start_in_ack, input logic [7:0] exp);
        bit got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.tx_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", 64'(got), 64'd1);
        if (got) begin
            for (int k = 0; k < hold; k++) begin
                chk("ack_valid_hold", 64'(bus.tx_valid), 64'd1);
                chk("ack_data_hold",  64'(bus.tx_data),  64'(exp));
                chk("ack_mode",       64'(bus.prold_info[65]), 64'd1);
                if (start_in_ack && k == 1) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
            end
            @(posedge clk); #1;
            bus.tx_ready = 1'b1;
            @(posedge clk); #1;
            bus.tx_ready = 1'b0;
            @(negedge clk);
            chk("idle_after_ack", 64'(bus.prold_info[65]), 64'd0);
            chk("tx_valid_after_ack", 64'(bus.tx_valid), 64'd0);
            @(negedge clk);
            chk("still_idle", 64'(bus.prold_info[65]), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    // Reference: pc = 4*index, data = word, ack from XOR of all size/data bytes.
    task automatic do_load(input int n, input bit bad, input int hold, input bit start_in_ack);
        logic [7:0] exp;
        pulse_start();
        cur_csum = 8'd0;
        send_word(32'(n), 1'b0, 32'd0);
        for (int i = 0; i < n; i++) begin
            send_word(wbuf[i], 1'b1, 32'(4 * i));
        end
`ifdef PROLD_CHECKSUM_EN
        begin
            logic [7:0] cb;
            cb  = bad ? (cur_csum ^ 8'h01) : cur_csum;
            exp = bad ? 8'h55 : 8'hAA;
            exp_ack.push_back(exp);
            send_byte(cb, 1'b0, 32'd0, 32'd0);
        end
`else
        exp = 8'hAA;
        exp_ack.push_back(exp);
`endif
        wait_ack(hold, start_in_ack, exp);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.tx_ready = 1'b0;
        b2b          = 1'b0;
        cur_csum     = 8'd0;

        #2;
        chk("reset_info_lo", bus.prold_info[63:0], 64'd0);
        chk("reset_info_hi", 64'(bus.prold_info[65:64]), 64'd0);
        chk("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("reset_tx_data",  64'(bus.tx_data),  64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word vector
        wbuf[0] = 32'h12345678;
        wbuf[1] = 32'h9ABCDEF0;
        do_load(2, 1'b0, 1, 1'b0);

        // Empty load
        do_load(0, 1'b0, 0, 1'b0);

        // Single word, wrong then right checksum
        wbuf[0] = 32'h00000001;
        do_load(1, 1'b1, 0, 1'b0);
        do_load(1, 1'b0, 0, 1'b0);

        // Reset in the middle of a word
        pulse_start();
        cur_csum = 8'd0;
        send_word(32'd2, 1'b0, 32'd0);
        send_byte(8'h12, 1'b0, 32'd0, 32'd0);
        send_byte(8'h34, 1'b0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midload_rst_mode", 64'(bus.prold_info[65]), 64'd0);
        chk("midload_rst_info", bus.prold_info[63:0], 64'd0);
        chk("midload_rst_order", 64'(bus.prold_info[64]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h56, 1'b0, 32'd0, 32'd0);
        send_byte(8'h78, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_rst", 64'(bus.prold_info[65]), 64'd0);
        wbuf[0] = 32'hCAFEF00D;
        do_load(1, 1'b0, 0, 1'b0);

        // Long ack stall with an ignored start
        wbuf[0] = 32'h0BADBEEF;
        do_load(1, 1'b0, 5, 1'b1);

        // Back-to-back bytes, three words
        b2b = 1'b1;
        wbuf[0] = 32'h11111111;
        wbuf[1] = 32'h22222222;
        wbuf[2] = 32'h33333333;
        do_load(3, 1'b0, 0, 1'b0);

        // Randomized loads
        for (int r = 0; r < 8; r++) begin
            int n;
            n   = $urandom_range(0, 6);
            b2b = bit'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            do_load(n, bit'($urandom_range(0, 1)), $urandom_range(0, 3),
                    bit'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("orders_drained", 64'(exp_ord.size()), 64'd0);
        chk("acks_drained",   64'(exp_ack.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
